uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter BAUD, default 9_600, the line bit rate.
REQ-002 SHALL have parameter INPUT_CLOCK, default 16_000_000, the i_clk frequency in Hz.
REQ-003 SHALL derive localparams CLOCKS_PER_BAUD = INPUT_CLOCK/BAUD (1666 at default) and HALF_BAUD = CLOCKS_PER_BAUD/2 (833); the counter is 13 bits wide.
REQ-004 i_clk  input  1  sole clock; all logic on its rising edge.
REQ-005 i_rst_n  input  1  reset, synchronous, active-low.
REQ-006 i_rx  input  1  asynchronous serial line, idle high, 8N1 framing, LSB first.
REQ-007 o_data  output  8  last correctly framed byte; held until the next good frame.
REQ-008 o_valid  output  1  one-cycle strobe: o_data has just been updated.
REQ-009 o_frame_err  output  1  one-cycle strobe: the stop bit sampled low; o_data is unchanged.
REQ-010 o_busy  output  1  high in every state except IDLE.

Function
REQ-011 i_rx SHALL pass through a 2-flop synchronizer; all logic uses only the synchronized value rxs.
REQ-012 SHALL keep a 3-bit history of rxs; each bit decision is the majority of rxs on the sample cycle and the two preceding cycles.
REQ-013 States: IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-014 IDLE: when rxs==0, go to START with counter=1.
REQ-015 START: counter increments; at counter==HALF_BAUD, a majority 1 (false start/glitch) returns to IDLE, and a majority 0 goes to DATA with counter=1 and bit index 0.
REQ-016 DATA: at counter==CLOCKS_PER_BAUD, shift the majority into the shift register LSB first and set counter=1; after bit index 7 go to STOP.
REQ-017 STOP: at counter==CLOCKS_PER_BAUD, majority 1 loads o_data from the shift register, pulses o_valid on the next cycle and goes to IDLE; majority 0 pulses o_frame_err on the next cycle and goes to WAIT_IDLE.
REQ-018 WAIT_IDLE: remain until rxs==1, then go to IDLE; a held-low line (break) produces exactly one o_frame_err and no o_valid.
REQ-019 Latency: with an i_rx falling edge sampled at cycle T0, o_valid SHALL assert at T0+3+HALF_BAUD+9*CLOCKS_PER_BAUD (15830 cycles at default).
REQ-020 o_valid and o_frame_err SHALL never assert in the same cycle, and each SHALL last exactly one cycle.
REQ-021 Back-to-back frames: a start edge in the cycle immediately after the STOP sample SHALL be accepted with no lost frame.
REQ-022 The counter SHALL never exceed CLOCKS_PER_BAUD and SHALL hold 0 in IDLE.

Reset
REQ-023 When i_rst_n==0 at a clock edge: state=IDLE, counter=0, bit index=0, shift register=0, o_data=8'h00, o_valid=0, o_frame_err=0, o_busy=0, synchronizer and history flops=1 (idle line).
REQ-024 Reset mid-frame SHALL abandon the frame with no strobe; reception resumes at the first falling edge after release.

Structure
REQ-025 State encodings and the CLOCKS_PER_BAUD/HALF_BAUD derivation SHALL live in a shared uart package that is also used by the transmitter.
REQ-026 The synchronizer plus majority-vote history SHALL be one sub-module, uart_rx_sync; everything else is flat.

Verification
REQ-027 Send 0xA5 at 9600 baud with the default clock -> one o_valid exactly 15830 cycles after the start edge, o_data=0xA5, o_frame_err never asserts.
REQ-028 Drive i_rx low for 100 cycles, then high -> returns to IDLE at HALF_BAUD, no strobes, o_busy falls.
REQ-029 Send 0x3C with the stop bit low, then hold low for 3 bit times -> exactly one o_frame_err, o_data keeps its prior value, o_busy stays high until i_rx rises.
REQ-030 Send back-to-back frames 0x00 and 0xFF with no idle gap -> two o_valid pulses carrying 0x00 then 0xFF.
REQ-031 Inject a 1-cycle high glitch at the mid-sample of data bit 3 of 0x00 -> o_data=0x00, as the majority rejects the glitch.
REQ-032 Assert i_rst_n=0 during data bit 4 of 0x55 -> no strobes and all outputs at reset values; a following 0x81 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encodings, baud-rate
// derivation helpers and the 3-sample majority vote.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } uart_state_t;

    // Wide enough for CLOCKS_PER_BAUD = 1666 and a few slower baud rates.
    localparam int CNT_W = 13;

    function automatic int clocks_per_baud(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    function automatic int half_baud(input int clk_hz, input int baud);
        return clocks_per_baud(clk_hz, baud) / 2;
    endfunction

    function automatic logic majority3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus a two-deep history so each
// bit decision is a majority over three consecutive synchronized samples.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_rx,
    output logic rxs,
    output logic rx_maj
);

    logic       meta;
    logic [1:0] hist;

    // Everything resets to 1 so a reset looks like an idle line, not a start bit.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            meta <= 1'b1;
            rxs  <= 1'b1;
            hist <= 2'b11;
        end else begin
            meta <= i_rx;
            rxs  <= meta;
            hist <= {hist[0], rxs};
        end
    end

    assign rx_maj = majority3({hist, rxs});

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start detection on the synchronized line, mid-bit
// majority sampling, one-cycle o_valid / o_frame_err strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD        = 9_600,
    parameter int INPUT_CLOCK = 16_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_busy
);

    localparam int CLOCKS_PER_BAUD = clocks_per_baud(INPUT_CLOCK, BAUD);
    localparam int HALF_BAUD       = half_baud(INPUT_CLOCK, BAUD);

    localparam logic [CNT_W-1:0] CPB_C  = CNT_W'(CLOCKS_PER_BAUD);
    localparam logic [CNT_W-1:0] HALF_C = CNT_W'(HALF_BAUD);

    logic rxs;
    logic rx_maj;

    uart_rx_sync u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_rx    (i_rx),
        .rxs     (rxs),
        .rx_maj  (rx_maj)
    );

    uart_state_t      state,   state_n;
    logic [CNT_W-1:0] counter, counter_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shreg,   shreg_n;
    logic [7:0]       data_n;
    logic             valid_n;
    logic             ferr_n;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            counter     <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            state       <= state_n;
            counter     <= counter_n;
            bit_idx     <= bit_idx_n;
            shreg       <= shreg_n;
            o_data      <= data_n;
            o_valid     <= valid_n;
            o_frame_err <= ferr_n;
        end
    end

    always_comb begin
        state_n   = state;
        counter_n = counter;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        data_n    = o_data;
        valid_n   = 1'b0;
        ferr_n    = 1'b0;

        case (state)
            ST_IDLE: begin
                counter_n = '0;
                if (!rxs) begin
                    state_n   = ST_START;
                    counter_n = CNT_W'(1);
                end
            end

            // Re-check the start bit at its centre so a short glitch is ignored.
            ST_START: begin
                counter_n = counter + 1'b1;
                if (counter == HALF_C) begin
                    if (rx_maj) begin
                        state_n   = ST_IDLE;
                        counter_n = '0;
                    end else begin
                        state_n   = ST_DATA;
                        counter_n = CNT_W'(1);
                        bit_idx_n = '0;
                    end
                end
            end

            ST_DATA: begin
                counter_n = counter + 1'b1;
                if (counter == CPB_C) begin
                    shreg_n   = {rx_maj, shreg[7:1]};
                    counter_n = CNT_W'(1);
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_n = ST_STOP;
                    end
                end
            end

            // Returning to IDLE right at the stop sample lets a back-to-back
            // start edge be seen on the very next cycle.
            ST_STOP: begin
                counter_n = counter + 1'b1;
                if (counter == CPB_C) begin
                    counter_n = '0;
                    if (rx_maj) begin
                        data_n  = shreg;
                        valid_n = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = ST_WAIT_IDLE;
                    end
                end
            end

            ST_WAIT_IDLE: begin
                counter_n = '0;
                if (rxs) begin
                    state_n = ST_IDLE;
                end
            end

            default: begin
                state_n   = ST_IDLE;
                counter_n = '0;
            end
        endcase
    end

    assign o_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a default-rate instance (exact latency, false start) and
// a fast instance (glitch, back-to-back, framing error, mid-frame reset).
module tb_uart_rx;

    // Hand-computed timing: 16 MHz / 9600 and 1.6 MHz / 9600 (integer division).
    localparam int CPB_D  = 1666;
    localparam int HALF_D = 833;
    localparam int LAT_D  = 15830;
    localparam int CPB_F  = 166;
    localparam int HALF_F = 83;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    logic       rst_n_d, rx_d, valid_d, ferr_d, busy_d;
    logic [7:0] data_d;
    logic       rst_n_f, rx_f, valid_f, ferr_f, busy_f;
    logic [7:0] data_f;

    uart_rx u_dut_d (
        .i_clk       (clk),
        .i_rst_n     (rst_n_d),
        .i_rx        (rx_d),
        .o_data      (data_d),
        .o_valid     (valid_d),
        .o_frame_err (ferr_d),
        .o_busy      (busy_d)
    );

    uart_rx #(.BAUD(9_600), .INPUT_CLOCK(1_600_000)) u_dut_f (
        .i_clk       (clk),
        .i_rst_n     (rst_n_f),
        .i_rx        (rx_f),
        .o_data      (data_f),
        .o_valid     (valid_f),
        .o_frame_err (ferr_f),
        .o_busy      (busy_f)
    );

    // Scoreboard entries: {frame_err, data}; a frame error expects o_data unchanged.
    logic [8:0] exp_q_d[$];
    logic [8:0] exp_q_f[$];
    int         t0_d     = 0;
    bit         lat_en_d = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input bit fast, input logic v);
        if (fast) rx_f = v;
        else      rx_d = v;
    endtask

    // glitch_bit >= 0 inserts a one-cycle high pulse at that bit's mid-sample.
    task automatic send_frame(input bit fast, input logic [7:0] d, input logic stop, input int glitch_bit);
        int cpb;
        int half;
        cpb  = fast ? CPB_F : CPB_D;
        half = fast ? HALF_F : HALF_D;
        set_line(fast, 1'b0);
        wait_cycles(cpb);
        for (int i = 0; i < 8; i++) begin
            set_line(fast, d[i]);
            if (i == glitch_bit) begin
                wait_cycles(half);
                set_line(fast, 1'b1);
                wait_cycles(1);
                set_line(fast, d[i]);
                wait_cycles(cpb - half - 1);
            end else begin
                wait_cycles(cpb);
            end
        end
        set_line(fast, stop);
        wait_cycles(cpb);
    endtask

    // Monitors: any strobe pops the expected queue; strobes with nothing expected fail.
    always @(negedge clk) begin
        logic [8:0] e;
        if (valid_d && ferr_d) begin
            checks++; errors++;
            $display("FAIL d_strobe_overlap: got valid=1 frame_err=1, required at most one");
        end else if (valid_d || ferr_d) begin
            checks++;
            if (exp_q_d.size() == 0) begin
                errors++;
                $display("FAIL d_unexpected: got err=%0b data=%0h, required no strobe", ferr_d, data_d);
            end else begin
                e = exp_q_d.pop_front();
                if ({ferr_d, data_d} !== e) begin
                    errors++;
                    $display("FAIL d_frame: got err=%0b data=%0h, required err=%0b data=%0h",
                             ferr_d, data_d, e[8], e[7:0]);
                end
            end
            if (valid_d && lat_en_d) begin
                lat_en_d = 1'b0;
                check("d_latency", cyc + 1 - t0_d, LAT_D);
            end
        end
    end

    always @(negedge clk) begin
        logic [8:0] e;
        if (valid_f && ferr_f) begin
            checks++; errors++;
            $display("FAIL f_strobe_overlap: got valid=1 frame_err=1, required at most one");
        end else if (valid_f || ferr_f) begin
            checks++;
            if (exp_q_f.size() == 0) begin
                errors++;
                $display("FAIL f_unexpected: got err=%0b data=%0h, required no strobe", ferr_f, data_f);
            end else begin
                e = exp_q_f.pop_front();
                if ({ferr_f, data_f} !== e) begin
                    errors++;
                    $display("FAIL f_frame: got err=%0b data=%0h, required err=%0b data=%0h",
                             ferr_f, data_f, e[8], e[7:0]);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: got no completion by cycle %0d, required completion", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        rst_n_d = 1'b0; rst_n_f = 1'b0;
        rx_d    = 1'b1; rx_f    = 1'b1;
        wait_cycles(5);
        check("d_reset_outputs", {data_d, valid_d, ferr_d, busy_d}, 11'h000);
        check("f_reset_outputs", {data_f, valid_f, ferr_f, busy_f}, 11'h000);
        rst_n_d = 1'b1; rst_n_f = 1'b1;
        wait_cycles(10);

        // Default rate: 0xA5 with exact start-edge-to-o_valid latency.
        t0_d     = cyc + 1;
        lat_en_d = 1'b1;
        exp_q_d.push_back({1'b0, 8'hA5});
        send_frame(1'b0, 8'hA5, 1'b1, -1);
        wait_cycles(20);
        check("d_latency_seen", {31'd0, lat_en_d}, 32'd0);

        // Default rate: 100-cycle low pulse is a false start, dropped at HALF_BAUD.
        t0_d = cyc + 1;
        rx_d = 1'b0;
        wait_cycles(50);
        check("d_false_start_busy", busy_d, 1);
        wait_cycles(50);
        rx_d = 1'b1;
        wait_cycles(733);
        check("d_false_start_busy_before_half", busy_d, 1);
        wait_cycles(3);
        check("d_false_start_idle_after_half", busy_d, 0);
        check("d_data_held", data_d, 8'hA5);

        // Fast rate: 0x00 with a glitch on bit 3, immediately followed by 0xFF.
        exp_q_f.push_back({1'b0, 8'h00});
        exp_q_f.push_back({1'b0, 8'hFF});
        send_frame(1'b1, 8'h00, 1'b1, 3);
        send_frame(1'b1, 8'hFF, 1'b1, -1);
        wait_cycles(20);
        check("f_back_to_back_drained", exp_q_f.size(), 0);

        // Fast rate: 0x3C with a low stop bit, line then held low (break).
        exp_q_f.push_back({1'b1, 8'hFF});
        send_frame(1'b1, 8'h3C, 1'b0, -1);
        wait_cycles(3 * CPB_F);
        check("f_break_busy", busy_f, 1);
        check("f_frame_err_seen", exp_q_f.size(), 0);
        rx_f = 1'b1;
        wait_cycles(5);
        check("f_break_released_idle", busy_f, 0);
        check("f_data_kept", data_f, 8'hFF);

        // Fast rate: reset in the middle of data bit 4 of 0x55.
        rx_f = 1'b0;
        wait_cycles(CPB_F);
        for (int i = 0; i < 4; i++) begin
            rx_f = (i % 2 == 0);
            wait_cycles(CPB_F);
        end
        rx_f = 1'b1;
        wait_cycles(HALF_F);
        rst_n_f = 1'b0;
        wait_cycles(3);
        check("f_midframe_reset_outputs", {data_f, valid_f, ferr_f, busy_f}, 11'h000);
        rst_n_f = 1'b1;
        wait_cycles(20);
        check("f_after_reset_idle", {data_f, valid_f, ferr_f, busy_f}, 11'h000);

        exp_q_f.push_back({1'b0, 8'h81});
        send_frame(1'b1, 8'h81, 1'b1, -1);
        wait_cycles(20);
        check("f_final_drained", exp_q_f.size(), 0);
        check("d_final_drained", exp_q_d.size(), 0);
        check("f_final_data", data_f, 8'h81);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
